// File: rtl/piso_stream_serializer.sv
//-----------------------------------------------------------------------------
// piso_stream_serializer
//
// Parallel-in / serial-out serializer with valid/ready handshakes on both
// sides. One input transfer captures a whole frame of NWORDS words. The frame
// is then emitted as NBEATS = NWORDS/LANES beats of LANES words each. The
// final beat of the frame is flagged with out_last_o.
//
// Parameters
//   DWIDTH     bits per word
//   NWORDS     words per input frame (>= 2)
//   LANES      words per output beat (NWORDS % LANES must be 0)
//   MSB_FIRST  0: word 0 leaves first, 1: word NWORDS-1 leaves first
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-high reset
//   in_valid_i   input frame valid
//   in_ready_o   frame can be accepted this cycle (combinational)
//   in_data_i    unpacked frame, in_data_i[i] is word i
//   out_valid_o  out_data_o holds a valid beat
//   out_ready_i  consumer accepts the beat
//   out_data_o   beat, out_data_o[j] is lane j
//   out_last_o   current beat is the final beat of the frame
//   out_par_o    XOR-reduce of the beat (only with PISO_PARITY_EN)
//   busy_o       frame in flight (same as out_valid_o)
//
// Build option
//   PISO_PARITY_EN  when defined, out_par_o is the registered XOR-reduce of
//                   all bits of out_data_o. When undefined, out_par_o is tied
//                   to 0 and no parity logic exists.
//
// Every output except in_ready_o comes straight from a flop.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module piso_stream_serializer #(
    parameter int DWIDTH    = 10,
    parameter int NWORDS    = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DWIDTH-1:0] in_data_i [NWORDS],
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o [LANES],
    output logic              out_last_o,
    output logic              out_par_o,
    output logic              busy_o
);

    localparam int NBEATS = NWORDS / LANES;
    localparam int CW     = $clog2(NBEATS + 1);

    // Illegal configurations are caught at elaboration.
    if ((NWORDS % LANES) != 0) begin : g_bad_lanes
        $error("piso_stream_serializer: NWORDS (%0d) must be a multiple of LANES (%0d)", NWORDS, LANES);
    end
    if (NWORDS < 2) begin : g_bad_nwords
        $error("piso_stream_serializer: NWORDS (%0d) must be at least 2", NWORDS);
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // shreg_q holds the words still to be emitted after the beat currently
    // on out_data_q, already in emission order (slot 0 leaves next).
    logic [DWIDTH-1:0] shreg_q     [NWORDS];
    logic [DWIDTH-1:0] shreg_d     [NWORDS];
    logic [DWIDTH-1:0] out_data_q  [LANES];
    logic [DWIDTH-1:0] out_data_d  [LANES];
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              out_last_q;
    logic              out_last_d;

    logic [DWIDTH-1:0] ordered_s    [NWORDS];
    logic [DWIDTH-1:0] load_shift_s [NWORDS];
    logic [DWIDTH-1:0] run_shift_s  [NWORDS];
    logic              out_valid_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              xfer_s;

    // Reorder the incoming frame so that slot 0 is always the first word out.
    for (genvar g = 0; g < NWORDS; g++) begin : g_order
        if (MSB_FIRST != 0) begin : g_msb
            assign ordered_s[g] = in_data_i[NWORDS-1-g];
        end else begin : g_lsb
            assign ordered_s[g] = in_data_i[g];
        end
    end

    // Shift-by-LANES views of the fresh frame and of the running register;
    // vacated tail slots are zero-filled.
    for (genvar g = 0; g < NWORDS; g++) begin : g_shift
        if (g + LANES < NWORDS) begin : g_mid
            assign load_shift_s[g] = ordered_s[g+LANES];
            assign run_shift_s[g]  = shreg_q[g+LANES];
        end else begin : g_tail
            assign load_shift_s[g] = '0;
            assign run_shift_s[g]  = '0;
        end
    end

    assign out_valid_s = (state_q == ST_SEND);
    assign in_ready_s  = !out_valid_s || (out_ready_i && out_last_q);
    assign accept_s    = in_valid_i && in_ready_s;
    assign xfer_s      = out_valid_s && out_ready_i;

`ifdef PISO_PARITY_EN
    logic out_par_q;
    logic out_par_d;

    // Even parity across every bit of one beat.
    function automatic logic beat_parity(input logic [DWIDTH-1:0] beat [LANES]);
        logic p;
        p = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            p = p ^ (^beat[j]);
        end
        return p;
    endfunction

    // Parity follows whatever is loaded into the output beat register, so it
    // holds automatically during a stall.
    always_comb begin
        out_par_d = beat_parity(out_data_d);
    end

    // Parity register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_par_q <= 1'b0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par_o = out_par_q;
`else
    assign out_par_o = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. A last-beat transfer that coincides with a new
    // accept stays in SEND so the next frame follows without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s && out_last_q && !accept_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs; in_ready_o is the only combinational output.
    always_comb begin
        out_valid_o = out_valid_s;
        busy_o      = out_valid_s;
        in_ready_o  = in_ready_s;
    end

    // Datapath next state: load on accept, advance by LANES words on transfer,
    // otherwise hold (this covers the stall case).
    always_comb begin
        shreg_d    = shreg_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        out_last_d = out_last_q;
        if (accept_s) begin
            for (int j = 0; j < LANES; j++) begin
                out_data_d[j] = ordered_s[j];
            end
            shreg_d    = load_shift_s;
            cnt_d      = '0;
            out_last_d = (NBEATS == 1);
        end else if (xfer_s) begin
            for (int j = 0; j < LANES; j++) begin
                out_data_d[j] = shreg_q[j];
            end
            shreg_d    = run_shift_s;
            cnt_d      = cnt_q + CW'(1'b1);
            // After the final beat the counter reaches NBEATS, clearing last.
            out_last_d = (cnt_d == CW'(NBEATS - 1));
        end else begin
            shreg_d    = shreg_q;
            out_data_d = out_data_q;
            cnt_d      = cnt_q;
            out_last_d = out_last_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                shreg_q[i] <= '0;
            end
            for (int j = 0; j < LANES; j++) begin
                out_data_q[j] <= '0;
            end
            cnt_q      <= '0;
            out_last_q <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_data_o = out_data_q;
    assign out_last_o = out_last_q;

endmodule

// File: tb/tb_piso_stream_serializer.sv
`timescale 1ns/1ps

module tb_piso_stream_serializer;

    logic       clk;
    logic       rst;

    // DUT 0: DWIDTH=10, NWORDS=8, LANES=1, MSB_FIRST=0
    logic       in_valid0;
    logic       in_ready0;
    logic [9:0] in_data0 [8];
    logic       out_valid0;
    logic       out_ready0;
    logic [9:0] out_data0 [1];
    logic       out_last0;
    logic       out_par0;
    logic       busy0;

    // DUT 1: DWIDTH=10, NWORDS=8, LANES=2, MSB_FIRST=1
    logic       in_valid1;
    logic       in_ready1;
    logic [9:0] in_data1 [8];
    logic       out_valid1;
    logic       out_ready1;
    logic [9:0] out_data1 [2];
    logic       out_last1;
    logic       out_par1;
    logic       busy1;

    piso_stream_serializer #(.DWIDTH(10), .NWORDS(8), .LANES(1), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0),
        .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
        .out_last_o(out_last0), .out_par_o(out_par0), .busy_o(busy0)
    );

    piso_stream_serializer #(.DWIDTH(10), .NWORDS(8), .LANES(2), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1), .in_data_i(in_data1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1), .out_data_o(out_data1),
        .out_last_o(out_last1), .out_par_o(out_par1), .busy_o(busy1)
    );

    typedef struct {
        logic [9:0] d0;
        logic [9:0] d1;
        logic       last;
        logic       par;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int xfer_cnt0   = 0;
    int first_cyc0  = 0;
    int last_cyc0   = 0;

    logic [9:0] fa [8];
    logic [9:0] fb [8];
    logic [9:0] fp [8];
    logic [9:0] f1 [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [9:0] a, input logic [9:0] b);
`ifdef PISO_PARITY_EN
        return (^a) ^ (^b);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard monitor for DUT 0.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid0 && out_ready0) begin
            if (xfer_cnt0 == 0) first_cyc0 = cyc;
            last_cyc0 = cyc;
            xfer_cnt0++;
            if (q0.size() == 0) begin
                chk("dut0_unexpected_beat", 32'(out_data0[0]), 32'h0);
            end else begin
                e = q0.pop_front();
                chk("dut0_data", 32'(out_data0[0]), 32'(e.d0));
                chk("dut0_last", 32'(out_last0), 32'(e.last));
                chk("dut0_par",  32'(out_par0),  32'(e.par));
            end
        end
    end

    // Scoreboard monitor for DUT 1.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_beat", 32'(out_data1[0]), 32'h0);
            end else begin
                e = q1.pop_front();
                chk("dut1_lane0", 32'(out_data1[0]), 32'(e.d0));
                chk("dut1_lane1", 32'(out_data1[1]), 32'(e.d1));
                chk("dut1_last",  32'(out_last1),    32'(e.last));
                chk("dut1_par",   32'(out_par1),     32'(e.par));
            end
        end
    end

    // Offer a frame to DUT 0 and wait (bounded) for acceptance. Returns just
    // after the accepting edge with in_valid0 still high.
    task automatic send0(input logic [9:0] w [8]);
        bit    ok;
        beat_t e;
        ok = 1'b0;
        in_data0  = w;
        in_valid0 = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready0 && !rst) begin
                ok = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    e.d0 = w[k]; e.d1 = 10'h000; e.last = (k == 7); e.par = exp_par(w[k], 10'h000);
                    q0.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("dut0_accept_timeout", 32'(ok), 32'h1);
    endtask

    task automatic drain0();
        for (int t = 0; t < 200 && q0.size() != 0; t++) @(posedge clk);
        #1;
        chk("dut0_drain", 32'(q0.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            fa[i] = 10'(i);
            fb[i] = 10'(100 + i);
            fp[i] = 10'h000;
            f1[i] = 10'(10 + i);
            in_data0[i] = 10'h000;
            in_data1[i] = 10'h000;
        end
        fp[0] = 10'h3FF;
        fp[1] = 10'h001;
        rst = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        out_ready0 = 1'b1; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid0", 32'(out_valid0), 32'h0);
        chk("rst_data0",  32'(out_data0[0]), 32'h0);
        chk("rst_last0",  32'(out_last0), 32'h0);
        chk("rst_par0",   32'(out_par0), 32'h0);
        chk("rst_busy0",  32'(busy0), 32'h0);
        chk("rst_ready0", 32'(in_ready0), 32'h1);
        chk("rst_valid1", 32'(out_valid1), 32'h0);
        chk("rst_data1",  32'({out_data1[1], out_data1[0]}), 32'h0);
        chk("rst_ready1", 32'(in_ready1), 32'h1);
        @(posedge clk); #1;

        // Case 1: 0..7, latency 1, last only on 7, in_ready high during beat 7
        send0(fa);
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("lat1_valid", 32'(out_valid0), 32'h1);
        chk("lat1_data",  32'(out_data0[0]), 32'h0);
        chk("lat1_busy",  32'(busy0), 32'h1);
        repeat (6) @(negedge clk);
        chk("beat6_inready", 32'(in_ready0), 32'h0);
        chk("beat6_last",    32'(out_last0), 32'h0);
        @(negedge clk);
        chk("beat7_inready", 32'(in_ready0), 32'h1);
        chk("beat7_last",    32'(out_last0), 32'h1);
        drain0();
        @(negedge clk);
        chk("idle_valid", 32'(out_valid0), 32'h0);

        // Case 2: LANES=2, MSB_FIRST=1
        begin
            beat_t e;
            e.d0 = 10'd17; e.d1 = 10'd16; e.last = 1'b0; e.par = exp_par(10'd17, 10'd16); q1.push_back(e);
            e.d0 = 10'd15; e.d1 = 10'd14; e.last = 1'b0; e.par = exp_par(10'd15, 10'd14); q1.push_back(e);
            e.d0 = 10'd13; e.d1 = 10'd12; e.last = 1'b0; e.par = exp_par(10'd13, 10'd12); q1.push_back(e);
            e.d0 = 10'd11; e.d1 = 10'd10; e.last = 1'b1; e.par = exp_par(10'd11, 10'd10); q1.push_back(e);
        end
        @(posedge clk); #1;
        in_data1 = f1;
        in_valid1 = 1'b1;
        @(negedge clk);
        chk("dut1_inready", 32'(in_ready1), 32'h1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int t = 0; t < 50 && q1.size() != 0; t++) @(posedge clk);
        #1;
        chk("dut1_drain", 32'(q1.size()), 32'h0);

        // Case 3: stall 3 cycles on beat 2
        @(posedge clk); #1;
        send0(fa);
        in_valid0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready0 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_data",    32'(out_data0[0]), 32'h2);
            chk("stall_inready", 32'(in_ready0), 32'h0);
            chk("stall_valid",   32'(out_valid0), 32'h1);
        end
        @(posedge clk);
        #1 out_ready0 = 1'b1;
        drain0();

        // Case 4: back-to-back A then B, 16 beats in 16 cycles
        @(posedge clk); #1;
        xfer_cnt0 = 0;
        send0(fa);
        send0(fb);
        in_valid0 = 1'b0;
        drain0();
        chk("b2b_count", 32'(xfer_cnt0), 32'd16);
        chk("b2b_span",  32'(last_cyc0 - first_cyc0), 32'd15);

        // Case 5: reset at beat 4, then a fresh frame
        @(posedge clk); #1;
        send0(fa);
        in_valid0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_data", 32'(out_data0[0]), 32'h4);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("midrst_valid",   32'(out_valid0), 32'h0);
        chk("midrst_data",    32'(out_data0[0]), 32'h0);
        chk("midrst_inready", 32'(in_ready0), 32'h1);
        chk("midrst_last",    32'(out_last0), 32'h0);
        @(posedge clk); #1;
        send0(fa);
        in_valid0 = 1'b0;
        @(negedge clk);
        chk("fresh_word0", 32'(out_data0[0]), 32'h0);
        drain0();

        // Case 6: parity frame 3FF, 001, 0...
        @(posedge clk); #1;
        send0(fp);
        in_valid0 = 1'b0;
        @(negedge clk);
`ifdef PISO_PARITY_EN
        chk("par_3ff", 32'(out_par0), 32'h0);
`else
        chk("par_off_3ff", 32'(out_par0), 32'h0);
`endif
        drain0();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
